// File: rtl/message_stream_arbiter_pkg.sv
// rtl/message_stream_arbiter_pkg.sv - shared header layout, FSM encoding and length defaults
package message_stream_arbiter_pkg;

    localparam int DEF_MSG_LENGTH_WIDTH  = 7;
    localparam int DEF_MAX_PACKET_LENGTH = 64;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;

    // The header flag always sits in the top bit of the word.
    function automatic int hdr_flag_bit(input int wdth);
        return wdth - 1;
    endfunction

endpackage

// File: rtl/message_stream_arbiter_picker.sv
// rtl/message_stream_arbiter_picker.sv - combinational round-robin pick starting after last index
module rr_priority_picker #(
    parameter int N_STREAMS     = 2,
    parameter int LOG_N_STREAMS = 1
) (
    input  logic [N_STREAMS-1:0]     req,
    input  logic [LOG_N_STREAMS-1:0] last,
    output logic                     found,
    output logic [LOG_N_STREAMS-1:0] idx
);

    // Scan from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        int cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = N_STREAMS; k >= 1; k--) begin
            cand = (int'(last) + k) % N_STREAMS;
            if (req[cand]) begin
                found = 1'b1;
                idx   = LOG_N_STREAMS'(cand);
            end
        end
    end

endmodule

// File: rtl/message_stream_arbiter.sv
// rtl/message_stream_arbiter.sv - packet-level round-robin merge of N header+payload streams
module message_stream_arbiter
    import message_stream_arbiter_pkg::*;
#(
    parameter int N_STREAMS         = 2,
    parameter int WDTH              = 32,
    parameter int MAX_PACKET_LENGTH = DEF_MAX_PACKET_LENGTH,
    parameter int MSG_LENGTH_WIDTH  = DEF_MSG_LENGTH_WIDTH,
    parameter int LOG_N_STREAMS     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_STREAMS*WDTH-1:0] in_data,
    input  logic [N_STREAMS-1:0]      in_empty,
    output logic [N_STREAMS-1:0]      in_pop,
    output logic [WDTH-1:0]           out_data,
    output logic                      out_nd,
    output logic [LOG_N_STREAMS-1:0]  grant,
    output logic                      error
);

    localparam int HDR_BIT = hdr_flag_bit(WDTH);
    localparam logic [MSG_LENGTH_WIDTH-1:0] MAX_LEN = MSG_LENGTH_WIDTH'(MAX_PACKET_LENGTH);
    localparam logic [MSG_LENGTH_WIDTH-1:0] ONE     = MSG_LENGTH_WIDTH'(1);

    arb_state_t                  state, state_nxt;
    logic [MSG_LENGTH_WIDTH-1:0] remaining, remaining_nxt;
    logic [LOG_N_STREAMS-1:0]    last_grant;
    logic [WDTH-1:0]             words [N_STREAMS];
    logic                        pick_found;
    logic [LOG_N_STREAMS-1:0]    pick_idx;
    logic [WDTH-1:0]             pick_word;
    logic [WDTH-1:0]             send_word;
    logic [MSG_LENGTH_WIDTH-1:0] pick_len;
    logic                        hdr_ok;
    logic                        emit;
    logic [WDTH-1:0]             emit_data;
    logic                        take_grant;
    logic                        set_error;

    always_comb begin
        for (int i = 0; i < N_STREAMS; i++) begin
            words[i] = in_data[i*WDTH +: WDTH];
        end
    end

    rr_priority_picker #(
        .N_STREAMS     (N_STREAMS),
        .LOG_N_STREAMS (LOG_N_STREAMS)
    ) u_picker (
        .req   (~in_empty),
        .last  (last_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_word = words[pick_idx];
    assign send_word = words[grant];
    assign pick_len  = pick_word[MSG_LENGTH_WIDTH-1:0];
    assign hdr_ok    = pick_word[HDR_BIT] && (pick_len <= MAX_LEN);

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        in_pop        = '0;
        emit          = 1'b0;
        emit_data     = pick_word;
        take_grant    = 1'b0;
        set_error     = 1'b0;
        case (state)
            ST_ARB: begin
                // A bad header is still consumed so the stream cannot wedge the arbiter.
                if (pick_found) begin
                    in_pop[pick_idx] = 1'b1;
                    take_grant       = 1'b1;
                    if (hdr_ok) begin
                        emit = 1'b1;
                        if (pick_len != '0) begin
                            state_nxt     = ST_SEND;
                            remaining_nxt = pick_len;
                        end
                    end else begin
                        set_error = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (!in_empty[grant]) begin
                    in_pop[grant] = 1'b1;
                    emit          = 1'b1;
                    emit_data     = send_word;
                    if (remaining != '0) begin
                        remaining_nxt = remaining - ONE;
                    end
                    if (remaining <= ONE) begin
                        state_nxt = ST_ARB;
                    end
                end
            end
        endcase
        if (!rst_n) begin
            in_pop = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_ARB;
            remaining  <= '0;
            out_data   <= '0;
            out_nd     <= 1'b0;
            grant      <= '0;
            last_grant <= LOG_N_STREAMS'(N_STREAMS - 1);
            error      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            out_nd    <= emit;
            if (emit) begin
                out_data <= emit_data;
            end
            if (take_grant) begin
                grant      <= pick_idx;
                last_grant <= pick_idx;
            end
            if (set_error) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_message_stream_arbiter.sv
// tb/tb_message_stream_arbiter.sv - directed vector and sequence bench for message_stream_arbiter
module tb_message_stream_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [1:0]  in_empty;
    logic [1:0]  in_pop;
    logic [31:0] out_data;
    logic        out_nd;
    logic [0:0]  grant;
    logic        error;

    always #5 clk = ~clk;

    message_stream_arbiter #(
        .N_STREAMS         (2),
        .WDTH              (32),
        .MAX_PACKET_LENGTH (64),
        .MSG_LENGTH_WIDTH  (7),
        .LOG_N_STREAMS     (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_empty (in_empty),
        .in_pop   (in_pop),
        .out_data (out_data),
        .out_nd   (out_nd),
        .grant    (grant),
        .error    (error)
    );

    typedef struct packed {
        logic [1:0]  empty;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  pop;
        logic        nd;
        logic [31:0] data;
        logic        gnt;
        logic        err;
    } vec_t;

    vec_t        vecs [8];
    int          ntests = 0;
    int          nfail  = 0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] outq [$];
    logic [31:0] expq [$];
    logic [1:0]  block;
    logic [1:0]  pops;
    logic        both_pop;
    int          ncyc;
    logic [63:0] ndlog, glog, errlog;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name);
        chk({name, "_count"}, 64'(outq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
            chk($sformatf("%s_w%0d", name, i), 64'(outq[i]), 64'(expq[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_empty = 2'b11;
        in_data  = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q0.delete();
        q1.delete();
        outq.delete();
        block    = 2'b00;
        ncyc     = 0;
        ndlog    = '0;
        glog     = '0;
        errlog   = '0;
        both_pop = 1'b0;
    endtask

    // One clock of the FIFO model: drive heads, record pops, retire popped words, log outputs.
    task automatic cycle();
        @(negedge clk);
        in_data  = {(q1.size() > 0) ? q1[0] : 32'h0, (q0.size() > 0) ? q0[0] : 32'h0};
        in_empty = {block[1] || (q1.size() == 0), block[0] || (q0.size() == 0)};
        #1;
        pops = in_pop;
        if (pops == 2'b11) both_pop = 1'b1;
        @(posedge clk);
        #1;
        if (pops[0] && q0.size() > 0) q0.delete(0);
        if (pops[1] && q1.size() > 0) q1.delete(0);
        ndlog[ncyc]  = out_nd;
        glog[ncyc]   = grant[0];
        errlog[ncyc] = error;
        if (out_nd) outq.push_back(out_data);
        ncyc++;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_empty = 2'b11;
        block    = 2'b00;

        //          empty  d0            d1            pop    nd    data          gnt   err
        vecs[0] = '{2'b11, 32'h0,        32'h0,        2'b00, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[1] = '{2'b10, 32'h80000000, 32'h0,        2'b01, 1'b1, 32'h80000000, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 32'h0,        32'h80001200, 2'b10, 1'b1, 32'h80001200, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 32'h80000000, 32'h80000100, 2'b01, 1'b1, 32'h80000000, 1'b0, 1'b0};
        vecs[4] = '{2'b10, 32'h00000003, 32'h0,        2'b01, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[5] = '{2'b10, 32'h80000041, 32'h0,        2'b01, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[6] = '{2'b10, 32'h80000040, 32'h0,        2'b01, 1'b1, 32'h80000040, 1'b0, 1'b0};
        vecs[7] = '{2'b01, 32'h0,        32'h7fffffff, 2'b10, 1'b0, 32'h0,        1'b1, 1'b1};

        do_reset();
        chk("rst_pop",  64'(in_pop),   64'h0);
        chk("rst_nd",   64'(out_nd),   64'h0);
        chk("rst_data", 64'(out_data), 64'h0);
        chk("rst_gnt",  64'(grant),    64'h0);
        chk("rst_err",  64'(error),    64'h0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            @(negedge clk);
            in_empty = vecs[v].empty;
            in_data  = {vecs[v].d1, vecs[v].d0};
            #1;
            chk($sformatf("vec%0d_pop", v), 64'(in_pop), 64'(vecs[v].pop));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_nd", v), 64'(out_nd), 64'(vecs[v].nd));
            if (vecs[v].nd) chk($sformatf("vec%0d_data", v), 64'(out_data), 64'(vecs[v].data));
            chk($sformatf("vec%0d_gnt", v), 64'(grant), 64'(vecs[v].gnt));
            chk($sformatf("vec%0d_err", v), 64'(error), 64'(vecs[v].err));
        end

        // Single packet L=3 on stream 0.
        do_reset();
        q0 = '{32'h80000003, 32'h000000a1, 32'h000000a2, 32'h000000a3};
        for (int i = 0; i < 8; i++) cycle();
        chk("one_nd", ndlog, 64'h0f);
        chk("one_gnt", glog, 64'h0);
        expq = '{32'h80000003, 32'h000000a1, 32'h000000a2, 32'h000000a3};
        chk_outs("one");

        // Two packets, back to back.
        do_reset();
        q0 = '{32'h80000002, 32'h000000a0, 32'h000000a1};
        q1 = '{32'h80001002, 32'h000000b0, 32'h000000b1};
        for (int i = 0; i < 8; i++) cycle();
        chk("b2b_nd", ndlog, 64'h3f);
        chk("b2b_gnt", glog, 64'hf8);
        chk("b2b_nodual", 64'(both_pop), 64'h0);
        expq = '{32'h80000002, 32'h000000a0, 32'h000000a1, 32'h80001002, 32'h000000b0, 32'h000000b1};
        chk_outs("b2b");

        // Stream 1 stalls mid-packet while stream 0 has a packet waiting.
        do_reset();
        q0 = '{32'h80000000, 32'h80004001, 32'h000000c1};
        q1 = '{32'h80003004, 32'h000000d1, 32'h000000d2, 32'h000000d3, 32'h000000d4};
        for (int i = 0; i < 3; i++) cycle();
        block = 2'b10;
        for (int i = 0; i < 5; i++) cycle();
        block = 2'b00;
        for (int i = 0; i < 8; i++) cycle();
        chk("stall_nd", ndlog, 64'h1f07);
        chk("stall_gnt", glog, 64'h07fe);
        expq = '{32'h80000000, 32'h80003004, 32'h000000d1, 32'h000000d2, 32'h000000d3,
                 32'h000000d4, 32'h80004001, 32'h000000c1};
        chk_outs("stall");

        // Header flag clear on stream 0, then a good packet on stream 1.
        do_reset();
        q0 = '{32'h00000005};
        q1 = '{32'h80002001, 32'h000000e1};
        for (int i = 0; i < 6; i++) cycle();
        chk("badflag_err", errlog, 64'h3f);
        chk("badflag_nd", ndlog, 64'h6);
        chk("badflag_gnt", glog, 64'h3e);
        expq = '{32'h80002001, 32'h000000e1};
        chk_outs("badflag");

        // Over-long header.
        do_reset();
        q0 = '{32'h80000041};
        for (int i = 0; i < 2; i++) cycle();
        chk("toolong_err", errlog, 64'h3);
        chk("toolong_nd", ndlog, 64'h0);

        // Zero-length headers on both streams alternate grant.
        do_reset();
        q0 = '{32'h80000000};
        q1 = '{32'h80000100};
        for (int i = 0; i < 3; i++) cycle();
        chk("zero_nd", ndlog, 64'h3);
        chk("zero_gnt", glog, 64'h6);
        expq = '{32'h80000000, 32'h80000100};
        chk_outs("zero");

        // Reset in the middle of a packet.
        do_reset();
        q0 = '{32'h80000003, 32'h000000a1, 32'h000000a2, 32'h000000a3};
        cycle();
        cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("midrst_pop",  64'(pops),     64'h0);
        chk("midrst_nd",   64'(out_nd),   64'h0);
        chk("midrst_data", 64'(out_data), 64'h0);
        chk("midrst_gnt",  64'(grant),    64'h0);
        chk("midrst_err",  64'(error),    64'h0);
        q0.delete();
        outq.delete();
        ncyc   = 0;
        ndlog  = '0;
        errlog = '0;
        q0 = '{32'h80000001, 32'h000000f1};
        for (int i = 0; i < 4; i++) cycle();
        chk("postrst_nd", ndlog, 64'h3);
        chk("postrst_err", errlog, 64'h0);
        expq = '{32'h80000001, 32'h000000f1};
        chk_outs("postrst");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
